// File: rtl/regfile_pkg.sv
// Shared encodings and helpers for the multi-port register file.
// Data is numbered big-endian: bit 0 is the MSB and byte 0 is the most significant byte.
package regfile_pkg;

    localparam logic [2:0] PPP_ALL   = 3'b000;
    localparam logic [2:0] PPP_UPPER = 3'b001;
    localparam logic [2:0] PPP_LOWER = 3'b010;
    localparam logic [2:0] PPP_EVEN  = 3'b011;
    localparam logic [2:0] PPP_ODD   = 3'b100;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Widest supported register is 256 bits; narrower users take the leading bits.
    localparam int unsigned MAX_NB = 32;

    typedef logic [0:MAX_NB-1]   bmask_t;
    typedef logic [0:8*MAX_NB-1] wmask_t;

    function automatic wmask_t expand_bmask(input bmask_t bm);
        wmask_t m;
        for (int i = 0; i < MAX_NB; i++) begin
            m[8*i +: 8] = {8{bm[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_mp_wmask.sv
// Combinational ppp decode into a bit-level write mask.
// The same mask serves both the write port and the bypass path.
module rf_wmask_gen
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic [2:0]        ppp_i,
    output logic [0:DATA_W-1] mask_o
);

    localparam int unsigned NB = DATA_W / 8;

    bmask_t bmask;
    wmask_t full_mask;
    logic   unused_mask_bits;

    always_comb begin
        bmask = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            unique case (ppp_i)
                PPP_UPPER: bmask[i] = (i < NB / 2);
                PPP_LOWER: bmask[i] = (i >= NB / 2);
                PPP_EVEN:  bmask[i] = (i[0] == 1'b0);
                PPP_ODD:   bmask[i] = i[0];
                default:   bmask[i] = 1'b1;
            endcase
        end
    end

    assign full_mask        = expand_bmask(bmask);
    assign mask_o           = full_mask[0:DATA_W-1];
    assign unused_mask_bits = ^full_mask;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD async read ports, one byte-masked write port,
// optional write-to-read bypass and a post-reset clear sequencer. Entry 0 reads as zero.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [0:NUM_RD*ADDR_W-1] rd_addr,
    output logic [0:NUM_RD*DATA_W-1] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [0:DATA_W-1]        wr_data,
    input  logic [2:0]               ppp,
    output logic                     busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [0:DATA_W-1]   mem_q [DEPTH];

    logic [0:DATA_W-1]   wmask;
    logic [0:DATA_W-1]   wr_merged;
    logic                wr_hit;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [0:DATA_W-1]   mem_wdata;
    logic [ADDR_W-1:0]   rd_addr_k [NUM_RD];

    rf_wmask_gen #(
        .DATA_W(DATA_W)
    ) u_wmask (
        .ppp_i (ppp),
        .mask_o(wmask)
    );

    assign busy      = (state_q == ST_CLEAR);
    assign wr_hit    = wr_en && !busy && (wr_addr != '0);
    // Unmasked bytes keep the stored value; positions are never shifted.
    assign wr_merged = (mem_q[wr_addr] & ~wmask) | (wr_data & wmask);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= ADDR_W'(1);
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_merged;
        unique case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                // Stop on the last entry so the pointer never wraps onto entry 0.
                if (clr_ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_RUN;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                mem_we = wr_hit;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_addr
        assign rd_addr_k[k] = rd_addr[k*ADDR_W +: ADDR_W];
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            if (!busy && (rd_addr_k[k] != '0)) begin
                if ((BYPASS != 0) && wr_hit && (rd_addr_k[k] == wr_addr)) begin
                    rd_data[k*DATA_W +: DATA_W] = wr_merged;
                end else begin
                    rd_data[k*DATA_W +: DATA_W] = mem_q[rd_addr_k[k]];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench: a default bypass build, a no-bypass build and a
// narrow 32-bit/8-entry/3-port build share one clock and reset.
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         rst;

    logic [0:9]   rd_ab;
    logic [0:127] rd_a, rd_b;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [0:63]  wr_data;
    logic [2:0]   ppp;
    logic         busy_a, busy_b;

    logic [0:8]   rd_addr_c;
    logic [0:95]  rd_c;
    logic         wr_en_c;
    logic [2:0]   wr_addr_c;
    logic [0:31]  wr_data_c;
    logic [2:0]   ppp_c;
    logic         busy_c;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .rd_addr(rd_ab), .rd_data(rd_a), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .ppp(ppp), .busy(busy_a)
    );

    regfile_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_ab), .rd_data(rd_b), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .ppp(ppp), .busy(busy_b)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(3), .NUM_RD(3), .BYPASS(1)) dut_c (
        .clk(clk), .rst(rst), .rd_addr(rd_addr_c), .rd_data(rd_c), .wr_en(wr_en_c),
        .wr_addr(wr_addr_c), .wr_data(wr_data_c), .ppp(ppp_c), .busy(busy_c)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d, input logic [2:0] p);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        ppp     = p;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wr_c(input logic [2:0] a, input logic [31:0] d, input logic [2:0] p);
        wr_en_c   = 1'b1;
        wr_addr_c = a;
        wr_data_c = d;
        ppp_c     = p;
        tick();
        wr_en_c   = 1'b0;
    endtask

    task automatic count_busy_a(output int n);
        n = 0;
        while (busy_a === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic count_busy_c(output int n);
        n = 0;
        while (busy_c === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; rd_ab = {5'd3, 5'd3}; wr_en = 1'b0; wr_addr = '0; wr_data = '0; ppp = '0;
        rd_addr_c = '0; wr_en_c = 1'b0; wr_addr_c = '0; wr_data_c = '0; ppp_c = '0;

        // Reset and clear sequence
        tick();
        chk("reset_busy_a", 64'(busy_a), 64'd1);
        chk("reset_busy_b", 64'(busy_b), 64'd1);
        chk("reset_rd_zero", rd_a[0:63], 64'd0);
        tick();
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = '1; ppp = 3'b000; rd_ab = {5'd5, 5'd5};
        cnt = 0;
        while (busy_a === 1'b1 && cnt < 100) begin
            if (cnt == 20) chk("busy_read_zero", rd_a[0:63], 64'd0);
            cnt++;
            tick();
        end
        wr_en = 1'b0;
        chk("clear_busy_cycles", 64'(cnt), 64'd31);
        chk("busy_b_low", 64'(busy_b), 64'd0);
        for (int i = 1; i < 32; i++) begin
            rd_ab = {5'(i), 5'(i)};
            #1;
            chk($sformatf("clear_r%0d_p0", i), rd_a[0:63], 64'd0);
            chk($sformatf("clear_r%0d_p1", i), rd_a[64:127], 64'd0);
        end
        rd_ab = {5'd5, 5'd5};
        #1;
        chk("busy_write_ignored_r5", rd_b[0:63], 64'd0);

        // Full write and r0
        wr(5'd3, 64'h0123456789ABCDEF, 3'b000);
        rd_ab = {5'd3, 5'd3};
        #1;
        chk("full_write_r3_a", rd_a[0:63], 64'h0123456789ABCDEF);
        chk("full_write_r3_b", rd_b[64:127], 64'h0123456789ABCDEF);
        wr(5'd0, 64'hFFFFFFFFFFFFFFFF, 3'b000);
        rd_ab = {5'd0, 5'd0};
        #1;
        chk("r0_zero_p0", rd_a[0:63], 64'd0);
        chk("r0_zero_p1", rd_b[64:127], 64'd0);

        // Selective writes over a preset
        rd_ab = {5'd7, 5'd7};
        wr(5'd7, 64'h0011223344556677, 3'b000);
        wr(5'd7, 64'hFFFFFFFFFFFFFFFF, 3'b011);
        #1;
        chk("ppp_even", rd_a[0:63], 64'hFF11FF33FF55FF77);
        wr(5'd7, 64'h0011223344556677, 3'b000);
        wr(5'd7, 64'hFFFFFFFFFFFFFFFF, 3'b100);
        #1;
        chk("ppp_odd", rd_a[0:63], 64'h00FF22FF44FF66FF);
        wr(5'd7, 64'h0011223344556677, 3'b000);
        wr(5'd7, 64'hFFFFFFFFFFFFFFFF, 3'b001);
        #1;
        chk("ppp_upper", rd_a[0:63], 64'hFFFFFFFF44556677);
        wr(5'd7, 64'h0011223344556677, 3'b000);
        wr(5'd7, 64'hFFFFFFFFFFFFFFFF, 3'b010);
        #1;
        chk("ppp_lower", rd_a[64:127], 64'h00112233FFFFFFFF);
        wr(5'd7, 64'h0011223344556677, 3'b000);
        wr(5'd7, 64'hFFFFFFFFFFFFFFFF, 3'b110);
        #1;
        chk("ppp_110_all", rd_a[0:63], 64'hFFFFFFFFFFFFFFFF);

        // Same-cycle bypass
        wr(5'd9, 64'h1111111111111111, 3'b000);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hAAAAAAAAAAAAAAAA; ppp = 3'b010;
        rd_ab = {5'd9, 5'd9};
        #1;
        chk("bypass_p0", rd_a[0:63], 64'h11111111AAAAAAAA);
        chk("bypass_p1", rd_a[64:127], 64'h11111111AAAAAAAA);
        chk("nobypass_p0", rd_b[0:63], 64'h1111111111111111);
        chk("nobypass_p1", rd_b[64:127], 64'h1111111111111111);
        rd_ab = {5'd9, 5'd3};
        #1;
        chk("bypass_other_port", rd_a[64:127], 64'h0123456789ABCDEF);
        tick();
        wr_en = 1'b0;
        #1;
        chk("nobypass_next_cycle", rd_b[0:63], 64'h11111111AAAAAAAA);

        // Reset in the middle of the clear sequence
        wr(5'd20, 64'h000000000000DEAD, 3'b000);
        rd_ab = {5'd20, 5'd20};
        #1;
        chk("preload_r20", rd_a[0:63], 64'h000000000000DEAD);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (10) tick();
        chk("midclear_busy", 64'(busy_a), 64'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        count_busy_a(cnt);
        chk("midclear_busy_cycles", 64'(cnt), 64'd31);
        #1;
        chk("midclear_r20_zero", rd_a[0:63], 64'd0);
        rd_ab = {5'd3, 5'd9};
        #1;
        chk("midclear_r3_zero", rd_b[0:63], 64'd0);
        chk("midclear_r9_zero", rd_b[64:127], 64'd0);

        // Narrow build: 32-bit, 8 entries, 3 ports
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        count_busy_c(cnt);
        chk("c_busy_cycles", 64'(cnt), 64'd7);
        wr_c(3'd2, 32'hFFFFFFFF, 3'b011);
        wr_c(3'd3, 32'h12345678, 3'b000);
        wr_c(3'd5, 32'hCAFEBABE, 3'b000);
        rd_addr_c = {3'd2, 3'd3, 3'd5};
        #1;
        chk("c_even_p0", 64'(rd_c[0:31]), 64'hFF00FF00);
        chk("c_p1", 64'(rd_c[32:63]), 64'h12345678);
        chk("c_p2", 64'(rd_c[64:95]), 64'hCAFEBABE);
        rd_addr_c = {3'd5, 3'd0, 3'd2};
        #1;
        chk("c_swap_p0", 64'(rd_c[0:31]), 64'hCAFEBABE);
        chk("c_r0_p1", 64'(rd_c[32:63]), 64'h0);
        chk("c_swap_p2", 64'(rd_c[64:95]), 64'hFF00FF00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
